// File: rtl/sdram_arbiter_if.sv
// Bundle of every signal between the arbiter, its three bus masters and the
// SDRAM controller.
//   master modport : the arbiter side (drives acks, read returns and the
//                    command bus towards the controller)
//   slave modport  : the environment side (masters + controller)
// Per-master fields are packed flat, master i at the i-th slice of its vector.
interface sdram_arbiter_if;
    // master request side
    logic [2:0]  m_req;
    logic [2:0]  m_write;
    logic [2:0]  m_burst;
    logic [77:0] m_address;
    logic [11:0] m_wstrb;
    logic [95:0] m_wdata;
    logic [26:0] m_tag;
    logic [2:0]  m_ack;
    // master read-return side
    logic [2:0]  m_rvalid;
    logic [2:0]  m_rlast;
    logic [31:0] m_rdata;
    logic [8:0]  m_rtag;
    logic [25:0] m_raddress;
    logic        protocol_error;
    // controller command side
    logic [2:0]  sdram_request;
    logic        sdram_ready;
    logic [25:0] sdram_address;
    logic        sdram_write;
    logic        sdram_burst;
    logic [3:0]  sdram_wstrb;
    logic [31:0] sdram_wdata;
    // controller return side
    logic [31:0] sdram_rdata;
    logic [8:0]  sdram_rtag;
    logic [25:0] sdram_raddress;
    logic [2:0]  sdram_rvalid;
    logic        sdram_complete;

    modport master (
        input  m_req, m_write, m_burst, m_address, m_wstrb, m_wdata, m_tag,
        output m_ack, m_rvalid, m_rlast, m_rdata, m_rtag, m_raddress, protocol_error,
        output sdram_request, sdram_address, sdram_write, sdram_burst, sdram_wstrb, sdram_wdata,
        input  sdram_ready, sdram_rdata, sdram_rtag, sdram_raddress, sdram_rvalid, sdram_complete
    );

    modport slave (
        output m_req, m_write, m_burst, m_address, m_wstrb, m_wdata, m_tag,
        input  m_ack, m_rvalid, m_rlast, m_rdata, m_rtag, m_raddress, protocol_error,
        input  sdram_request, sdram_address, sdram_write, sdram_burst, sdram_wstrb, sdram_wdata,
        output sdram_ready, sdram_rdata, sdram_rtag, sdram_raddress, sdram_rvalid, sdram_complete
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter in front of the SDRAM controller for three bus masters.
// One registered command is presented at a time and held until the controller
// accepts it; a new winner is captured in the accept cycle so commands can go
// back to back. Per-master counters track outstanding read words and the
// returned words are routed back with a last-word marker.
//   clock : system clock
//   reset : asynchronous, active-low
//   bus   : sdram_arbiter_if.master (master request/return + controller bus)
// BURST_WORDS must match the controller burst length; 2**CNT_W > BURST_WORDS.
module sdram_arbiter #(
    parameter int BURST_WORDS = 16,
    parameter int CNT_W       = 5
) (
    input  logic            clock,
    input  logic            reset,
    sdram_arbiter_if.master bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t                 state_reg, state_next;
    logic [1:0]             ptr_reg, ptr_next;
    logic [2:0]             req_reg, req_next;
    logic [25:0]            addr_reg, addr_next;
    logic                   write_reg, write_next;
    logic                   burst_reg, burst_next;
    logic [3:0]             wstrb_reg, wstrb_next;
    logic [31:0]            wdata_reg, wdata_next;
    logic [2:0][CNT_W-1:0]  cnt_reg, cnt_next;
    logic [2:0]             rvalid_reg, rlast_reg, rlast_next;
    logic [31:0]            rdata_reg;
    logic [8:0]             rtag_reg;
    logic [25:0]            raddr_reg;
    logic                   error_reg, error_next;

    logic [2:0]             eligible, load, underflow, rv_sel;
    logic                   accept, found, capture, multi_hit;
    logic [1:0]             winner;
    logic [25:0]            addr_m  [3];
    logic [3:0]             wstrb_m [3];
    logic [31:0]            wdata_m [3];
    logic [8:0]             tag_m   [3];

    // sdram_complete is not needed: the word counters are authoritative.
    logic unused_inputs;
    assign unused_inputs = bus.sdram_complete;

    // Search position k from the round-robin pointer, wrapping modulo 3.
    function automatic logic [1:0] rot(input logic [1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= 3) s = s - 3;
        return s[1:0];
    endfunction

    assign accept = bus.sdram_ready && (req_reg != 3'b000);

    // Only the lowest set return bit is routed; more than one is an error.
    assign rv_sel    = bus.sdram_rvalid & (~bus.sdram_rvalid + 3'd1);
    assign multi_hit = (bus.sdram_rvalid & (bus.sdram_rvalid - 3'd1)) != 3'b000;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_master
            assign addr_m[gi]  = bus.m_address[26*gi +: 26];
            assign wstrb_m[gi] = bus.m_wstrb[4*gi +: 4];
            assign wdata_m[gi] = bus.m_wdata[32*gi +: 32];
            assign tag_m[gi]   = bus.m_tag[9*gi +: 9];

            // A master with reads in flight waits, so its next command
            // cannot overtake its own read data.
            assign eligible[gi]   = bus.m_req[gi] && (cnt_reg[gi] == '0);
            assign load[gi]       = capture && (winner == 2'(gi)) && !bus.m_write[gi];
            assign underflow[gi]  = rv_sel[gi] && (cnt_reg[gi] == '0);
            assign rlast_next[gi] = rv_sel[gi] && (cnt_reg[gi] == CNT_W'(1));

            // A capture only happens with cnt == 0, so load is a plain
            // assignment and can never coincide with a decrement.
            assign cnt_next[gi] = load[gi] ? (bus.m_burst[gi] ? CNT_W'(BURST_WORDS) : CNT_W'(1))
                                : (rv_sel[gi] && (cnt_reg[gi] != '0)) ? cnt_reg[gi] - CNT_W'(1)
                                : cnt_reg[gi];
        end
    endgenerate

    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!found && eligible[rot(ptr_reg, k)]) begin
                found  = 1'b1;
                winner = rot(ptr_reg, k);
            end
        end
    end

    // The output registers may take a new command when idle or when the
    // presented one is accepted this cycle. Gated by reset so the ack is
    // quiet while reset is held.
    assign capture     = found && reset && ((state_reg == IDLE) || accept);
    assign bus.m_ack   = capture ? (3'b001 << winner) : 3'b000;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        req_next   = req_reg;
        addr_next  = addr_reg;
        write_next = write_reg;
        burst_next = burst_reg;
        wstrb_next = wstrb_reg;
        wdata_next = wdata_reg;
        if (capture) begin
            state_next = HOLD;
            ptr_next   = (winner == 2'd2) ? 2'd0 : winner + 2'd1;
            req_next   = 3'b001 << winner;
            addr_next  = addr_m[winner];
            write_next = bus.m_write[winner];
            burst_next = !bus.m_write[winner] && bus.m_burst[winner];
            wstrb_next = wstrb_m[winner];
            // Reads carry their tag in the low bits of the data field.
            wdata_next = bus.m_write[winner] ? wdata_m[winner] : {23'd0, tag_m[winner]};
        end else if ((state_reg == HOLD) && accept) begin
            state_next = IDLE;
            req_next   = 3'b000;
        end
    end

    assign error_next = error_reg || (underflow != 3'b000) || multi_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            ptr_reg    <= 2'd0;
            req_reg    <= 3'b000;
            addr_reg   <= '0;
            write_reg  <= 1'b0;
            burst_reg  <= 1'b0;
            wstrb_reg  <= '0;
            wdata_reg  <= '0;
            cnt_reg    <= '0;
            rvalid_reg <= 3'b000;
            rlast_reg  <= 3'b000;
            rdata_reg  <= '0;
            rtag_reg   <= '0;
            raddr_reg  <= '0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            req_reg    <= req_next;
            addr_reg   <= addr_next;
            write_reg  <= write_next;
            burst_reg  <= burst_next;
            wstrb_reg  <= wstrb_next;
            wdata_reg  <= wdata_next;
            cnt_reg    <= cnt_next;
            rvalid_reg <= rv_sel;
            rlast_reg  <= rlast_next;
            rdata_reg  <= bus.sdram_rdata;
            rtag_reg   <= bus.sdram_rtag;
            raddr_reg  <= bus.sdram_raddress;
            error_reg  <= error_next;
        end
    end

    assign bus.sdram_request  = req_reg;
    assign bus.sdram_address  = addr_reg;
    assign bus.sdram_write    = write_reg;
    assign bus.sdram_burst    = burst_reg;
    assign bus.sdram_wstrb    = wstrb_reg;
    assign bus.sdram_wdata    = wdata_reg;
    assign bus.m_rvalid       = rvalid_reg;
    assign bus.m_rlast        = rlast_reg;
    assign bus.m_rdata        = rdata_reg;
    assign bus.m_rtag         = rtag_reg;
    assign bus.m_raddress     = raddr_reg;
    assign bus.protocol_error = error_reg;
endmodule
